// File: rtl/uart8_transmitter.sv
// uart8_transmitter
//   8N1 UART transmitter: one start bit (low), eight data bits LSB first,
//   one stop bit (high), no parity. A one-entry holding register lets the
//   next byte be queued while a frame is on the line, so consecutive frames
//   leave with no idle gap between the stop bit and the next start bit.
//
// Ports
//   clk       bit-timing clock, TICKS_PER_BIT clocks per serial bit
//   rst_n     asynchronous active-low reset
//   en        synchronous enable; low forces the RESET state (frame aborted,
//             queued byte dropped, no done pulse)
//   start     request to load `in` into the holding register
//   in        byte to transmit
//   ready     holding register empty
//   busy      frame on the line (START_BIT, DATA_BITS or STOP_BIT)
//   done      one-clock pulse after a frame's stop bit completes
//   overrun   one-clock pulse after a start that arrived while ready=0
//   out       serial line, idle high, driven straight from a flop
//   dbg_state current FSM state encoding, for checkers and debug
//
// Handshake: a byte is transferred on a clock edge where start=1 and
// ready=1; ready drops at that edge and rises again at the edge where the
// byte moves into the shift register. A start seen while ready=0 (and the
// FSM is out of RESET) is dropped and reported on overrun; the queued byte
// is left untouched.

`timescale 1ns/1ps

module uart8_transmitter #(
  parameter int TICKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       start,
  input  logic [7:0] in,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic       out,
  output logic [2:0] dbg_state
);

  localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_IDLE      = 3'd1,
    ST_START_BIT = 3'd2,
    ST_DATA_BITS = 3'd3,
    ST_STOP_BIT  = 3'd4
  } state_t;

  state_t        state;
  logic [TW-1:0] tick;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic [7:0]    hold_reg;
  logic          hold_full;
  logic          tick_wrap;
  logic          accept;

  assign tick_wrap = (tick == TICK_MAX);
  assign accept    = start & ready;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RESET;
      tick      <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      out       <= 1'b1;
    end else begin
      done    <= 1'b0;
      overrun <= 1'b0;

      if (!en) begin
        // Abort whatever is in flight and drop any queued byte.
        state     <= ST_RESET;
        tick      <= '0;
        bit_idx   <= '0;
        hold_reg  <= '0;
        hold_full <= 1'b0;
        ready     <= 1'b0;
        busy      <= 1'b0;
        out       <= 1'b1;
      end else begin
        // Holding register capture runs in every active state. In RESET
        // ready is low, so neither branch can fire there.
        if (state != ST_RESET) begin
          if (accept) begin
            hold_reg  <= in;
            hold_full <= 1'b1;
            ready     <= 1'b0;
          end else if (start) begin
            overrun <= 1'b1;
          end
        end

        case (state)
          ST_RESET: begin
            out     <= 1'b1;
            busy    <= 1'b0;
            tick    <= '0;
            bit_idx <= '0;
            ready   <= 1'b1;
            state   <= ST_IDLE;
          end

          ST_IDLE: begin
            out  <= 1'b1;
            busy <= 1'b0;
            if (hold_full) begin
              shift_reg <= hold_reg;
              hold_full <= 1'b0;
              ready     <= 1'b1;
              out       <= 1'b0;
              busy      <= 1'b1;
              tick      <= '0;
              state     <= ST_START_BIT;
            end
          end

          ST_START_BIT: begin
            if (tick_wrap) begin
              tick    <= '0;
              out     <= shift_reg[0];
              bit_idx <= '0;
              state   <= ST_DATA_BITS;
            end else begin
              tick <= tick + TW'(1);
            end
          end

          ST_DATA_BITS: begin
            if (tick_wrap) begin
              tick <= '0;
              if (bit_idx == 3'd7) begin
                out   <= 1'b1;
                state <= ST_STOP_BIT;
              end else begin
                // shift_reg[0] is the bit currently on the line.
                out       <= shift_reg[1];
                shift_reg <= {1'b0, shift_reg[7:1]};
                bit_idx   <= bit_idx + 3'd1;
              end
            end else begin
              tick <= tick + TW'(1);
            end
          end

          ST_STOP_BIT: begin
            if (tick_wrap) begin
              tick <= '0;
              done <= 1'b1;
              // A byte queued before this edge starts the next frame right
              // away; one arriving on this very edge goes through IDLE.
              if (hold_full) begin
                shift_reg <= hold_reg;
                hold_full <= 1'b0;
                ready     <= 1'b1;
                out       <= 1'b0;
                state     <= ST_START_BIT;
              end else begin
                busy  <= 1'b0;
                state <= ST_IDLE;
              end
            end else begin
              tick <= tick + TW'(1);
            end
          end

          default: begin
            state     <= ST_RESET;
            tick      <= '0;
            bit_idx   <= '0;
            hold_full <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            out       <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart8_transmitter.sv
// Bench for uart8_transmitter: table of single frames checked cycle by
// cycle, hand-written sequences for queuing, overrun, enable drop, async
// reset and a TICKS_PER_BIT=4 instance, plus a line monitor that decodes
// every frame and compares it against an expected-byte queue.

`timescale 1ns/1ps

module tb_uart8_transmitter;

  localparam int T  = 16;
  localparam int T4 = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main DUT (TICKS_PER_BIT = 16)
  logic       en    = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in    = 8'h00;
  logic       ready, busy, done, overrun, out;
  logic [2:0] dbg_state;

  // small DUT (TICKS_PER_BIT = 4)
  logic       en4    = 1'b0;
  logic       start4 = 1'b0;
  logic [7:0] in4    = 8'h00;
  logic       ready4, busy4, done4, overrun4, out4;
  logic [2:0] dbg_state4;

  uart8_transmitter #(.TICKS_PER_BIT(T)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .in(in),
    .ready(ready), .busy(busy), .done(done), .overrun(overrun), .out(out),
    .dbg_state(dbg_state)
  );

  uart8_transmitter #(.TICKS_PER_BIT(T4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .start(start4), .in(in4),
    .ready(ready4), .busy(busy4), .done(done4), .overrun(overrun4), .out(out4),
    .dbg_state(dbg_state4)
  );

  // ---------------- bookkeeping ----------------
  int         tests_run    = 0;
  int         tests_failed = 0;
  string      phase        = "init";
  logic [7:0] exp_q[$];

  function automatic void chk_b(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s [%s]: got %b expected %b at %0t", name, phase, act, exp, $time);
    end
  endfunction

  function automatic void chk_v(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s [%s]: got %0h expected %0h at %0t", name, phase, act, exp, $time);
    end
  endfunction

  // ---------------- line monitor / scoreboard ----------------
  bit         mon_active = 1'b0;
  int         mon_cnt    = 0;
  logic [9:0] mon_bits   = '0;
  logic [7:0] mon_exp;

  always begin
    @(posedge clk);
    #1;
    if (mon_active && mon_cnt == 10*T) begin
      chk_b("mon_done", done, 1'b1);
      chk_b("mon_start_bit", mon_bits[0], 1'b0);
      chk_b("mon_stop_bit", mon_bits[9], 1'b1);
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL mon_unexpected_frame [%s]: got %02h expected no frame", phase, mon_bits[8:1]);
      end else begin
        mon_exp = exp_q.pop_front();
        chk_v("mon_byte", 32'(mon_bits[8:1]), 32'(mon_exp));
      end
      mon_active = 1'b0;
    end else if (mon_active && !busy) begin
      // frame aborted by en or reset: its byte never completes
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      mon_active = 1'b0;
    end
    if (!mon_active && busy && !out) begin
      mon_active = 1'b1;
      mon_cnt    = 0;
      mon_bits   = '0;
    end
    if (mon_active) begin
      if (mon_cnt % T == T/2) mon_bits[mon_cnt/T] = out;
      mon_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [7:0] d, input logic acc);
    chk_b("ready_before_start", ready, acc);
    start = 1'b1;
    in    = d;
    step();
    start = 1'b0;
    in    = 8'($urandom_range(0, 255));
    if (acc) exp_q.push_back(d);
    chk_b("overrun_flag", overrun, !acc);
  endtask

  // Send from IDLE and check the line every clock of the frame.
  task automatic tx_and_check(input logic [7:0] d, input logic [9:0] frame);
    send(d, 1'b1);
    chk_b("ready_after_accept", ready, 1'b0);
    for (int k = 1; k <= 10*T; k++) begin
      step();
      chk_b("line_bit", out, frame[(k-1)/T]);
      chk_b("busy_in_frame", busy, 1'b1);
      chk_b("done_early", done, 1'b0);
      if (k == 1) chk_b("ready_after_load", ready, 1'b1);
    end
    step();
    chk_b("done_pulse", done, 1'b1);
    chk_b("busy_end", busy, 1'b0);
    chk_b("out_idle", out, 1'b1);
    step();
    chk_b("done_single", done, 1'b0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // frame[0] = start bit ... frame[9] = stop bit
  } vec_t;

  vec_t       vecs[5];
  logic [9:0] frame81;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 10'b1_10100101_0};
    vecs[1] = '{8'h00, 10'b1_00000000_0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0};
    vecs[3] = '{8'h3C, 10'b1_00111100_0};
    vecs[4] = '{8'h81, 10'b1_10000001_0};
    frame81 = 10'b1_10000001_0;

    // ---- reset ----
    phase = "reset";
    step_n(3);
    chk_b("rst_out", out, 1'b1);
    chk_b("rst_ready", ready, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_done", done, 1'b0);
    chk_b("rst_overrun", overrun, 1'b0);
    chk_v("rst_state", 32'(dbg_state), 32'd0);
    en  = 1'b1;
    en4 = 1'b1;
    rst_n = 1'b1;
    step();
    chk_v("idle_state", 32'(dbg_state), 32'd1);
    chk_b("idle_ready", ready, 1'b1);
    chk_b("idle_out", out, 1'b1);
    chk_b("idle_busy", busy, 1'b0);

    // ---- single frames from the table ----
    phase = "table";
    for (int v = 0; v < 5; v++) begin
      tx_and_check(vecs[v].data, vecs[v].frame);
      step_n(2);
    end

    // ---- back-to-back with a queued byte ----
    phase = "back_to_back";
    send(8'h55, 1'b1);           // edge N
    step_n(39);                  // N+39
    send(8'h0F, 1'b1);           // edge N+40, first frame in DATA_BITS
    for (int k = 41; k <= 160; k++) begin
      step();
      chk_b("b2b_ready_held", ready, 1'b0);
      chk_b("b2b_no_done", done, 1'b0);
    end
    step();                      // N+161
    chk_b("b2b_done1", done, 1'b1);
    chk_b("b2b_ready_load", ready, 1'b1);
    chk_b("b2b_out_start", out, 1'b0);
    chk_b("b2b_busy_held", busy, 1'b1);
    for (int k = 162; k <= 320; k++) begin
      step();
      chk_b("b2b_busy2", busy, 1'b1);
      chk_b("b2b_no_done2", done, 1'b0);
    end
    step();                      // N+321
    chk_b("b2b_done2", done, 1'b1);
    chk_b("b2b_idle", busy, 1'b0);
    step();
    chk_b("b2b_done2_single", done, 1'b0);

    // ---- overrun ----
    phase = "overrun";
    send(8'hAA, 1'b1);
    step_n(5);
    send(8'h0F, 1'b1);
    step_n(5);
    send(8'h33, 1'b0);
    step();
    chk_b("overrun_single", overrun, 1'b0);
    chk_b("overrun_queue_kept", ready, 1'b0);
    step_n(2*10*T + 10);

    // ---- random burst, one byte always queued behind the line ----
    phase = "random_burst";
    send(8'($urandom_range(0, 255)), 1'b1);
    step_n(3);
    send(8'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < 3; i++) begin
      step_n(10*T);
      send(8'($urandom_range(0, 255)), 1'b1);
    end
    step_n(2*10*T + 10);

    // ---- en drop during data bit 3 ----
    phase = "en_drop";
    send(8'hC3, 1'b1);           // edge N
    step_n(69);                  // bit 3 interval is N+65..N+80
    chk_b("en_bit3", out, 1'b0);
    en = 1'b0;
    step();
    chk_b("en_out_high", out, 1'b1);
    chk_b("en_busy_low", busy, 1'b0);
    chk_b("en_ready_low", ready, 1'b0);
    chk_v("en_state", 32'(dbg_state), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk_b("en_off_ready", ready, 1'b0);
      chk_b("en_off_done", done, 1'b0);
      chk_b("en_off_out", out, 1'b1);
    end
    en = 1'b1;
    step();
    chk_b("en_back_ready", ready, 1'b1);
    chk_v("en_back_state", 32'(dbg_state), 32'd1);
    tx_and_check(8'hFF, 10'b1_11111111_0);

    // ---- async reset during START_BIT ----
    phase = "async_reset";
    send(8'h96, 1'b1);
    step_n(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_b("arst_out", out, 1'b1);
    chk_b("arst_busy", busy, 1'b0);
    chk_b("arst_ready", ready, 1'b0);
    chk_v("arst_state", 32'(dbg_state), 32'd0);
    step_n(3);
    chk_b("arst_hold_out", out, 1'b1);
    rst_n = 1'b1;
    step();
    chk_b("arst_release_ready", ready, 1'b1);
    tx_and_check(8'h00, 10'b1_00000000_0);

    // ---- TICKS_PER_BIT = 4 instance ----
    phase = "ticks4";
    step_n(2);
    chk_b("t4_ready", ready4, 1'b1);
    start4 = 1'b1;
    in4    = 8'h81;
    step();
    start4 = 1'b0;
    chk_b("t4_ready_accept", ready4, 1'b0);
    for (int k = 1; k <= 10*T4; k++) begin
      step();
      chk_b("t4_line", out4, frame81[(k-1)/T4]);
      chk_b("t4_busy", busy4, 1'b1);
      chk_b("t4_no_done", done4, 1'b0);
      if (k == 1) chk_v("t4_state", 32'(dbg_state4), 32'd2);
    end
    step();
    chk_b("t4_done", done4, 1'b1);
    chk_b("t4_idle", busy4, 1'b0);
    chk_b("t4_overrun", overrun4, 1'b0);

    // ---- wrap up ----
    phase = "final";
    step_n(5);
    chk_v("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
